// File: rtl/decode_regfile_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_regfile_stage_pkg
// Shared constants and types for the decode-side register file stage.
//   XLEN     : datapath width
//   NREGS    : number of architectural registers
//   AW       : register index width (NREGS == 2**AW)
//   ZERO_REG : index of the hard-wired zero register
//   idex_t   : contents of the ID/EX pipeline register
// -----------------------------------------------------------------------------
package decode_regfile_stage_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [XLEN-1:0] rs1Data;
        logic [XLEN-1:0] rs2Data;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic            valid;
    } idex_t;

endpackage

// File: rtl/decode_regfile_stage_if.sv
// -----------------------------------------------------------------------------
// decode_regfile_stage_if
// Writeback result bus travelling from the writeback stage back to decode.
//   RdD         : writeback destination register
//   ResultD     : writeback data
//   RegWriteEnD : writeback write enable
// Modports: master = writeback stage (drives), slave = decode stage (consumes).
// -----------------------------------------------------------------------------
interface decode_regfile_stage_if;
    import decode_regfile_stage_pkg::*;

    logic [AW-1:0]   RdD;
    logic [XLEN-1:0] ResultD;
    logic            RegWriteEnD;

    modport master (output RdD, output ResultD, output RegWriteEnD);
    modport slave  (input  RdD, input  ResultD, input  RegWriteEnD);

endinterface

// File: rtl/decode_regfile_stage_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// Architectural register file: two combinational read ports, one write port.
// Register 0 reads as zero and ignores writes. A write in the same cycle as a
// read of the same (non-zero) index is bypassed to the read port.
//   clk, rst          : clock, synchronous active-low clear of all registers
//   wrAddr/Data/En    : write port, committed at the rising edge
//   rdAddr1, rdAddr2  : read addresses
//   rdData1, rdData2  : read data (bypassed)
// -----------------------------------------------------------------------------
module reg_file_2r1w
    import decode_regfile_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wrAddr,
    input  logic [XLEN-1:0] wrData,
    input  logic            wrEn,
    input  logic [AW-1:0]   rdAddr1,
    input  logic [AW-1:0]   rdAddr2,
    output logic [XLEN-1:0] rdData1,
    output logic [XLEN-1:0] rdData2
);

    if (NREGS != (1 << AW)) begin : gBadSize
        $error("reg_file_2r1w: NREGS must equal 2**AW");
    end

    logic [XLEN-1:0] regs [NREGS];
    logic            writeHit;

    // A write to the zero register is dropped before it reaches storage or bypass.
    assign writeHit = wrEn && (wrAddr != AW'(ZERO_REG));

    // NOTE: the array is cleared on reset because the architecture defines every
    // register as 0 after reset; this rules out a RAM macro without reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment so all
                // registers update together at the edge, independent of order.
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[wrAddr] <= wrData;
        end
    end

    function automatic logic [XLEN-1:0] readPort(input logic [AW-1:0] addr);
        if (addr == AW'(ZERO_REG)) begin
            return '0;
        end else if (writeHit && (addr == wrAddr)) begin
            return wrData;
        end else begin
            return regs[addr];
        end
    endfunction

    always_comb begin
        rdData1 = readPort(rdAddr1);
        rdData2 = readPort(rdAddr2);
    end

endmodule

// File: rtl/decode_regfile_stage.sv
// -----------------------------------------------------------------------------
// decode_regfile_stage
// Commits the writeback bus into the register file, reads both source operands
// for the decode instruction (with same-cycle write bypass) and registers them
// into the ID/EX pipeline register.
//   clk, rst         : clock, synchronous active-low reset
//   wbBus (slave)    : RdD / ResultD / RegWriteEnD writeback bus
//   Rs1D, Rs2D, RdInD: register indices of the decode instruction
//   ValidD           : decode slot holds a real instruction
//   StallE, FlushE   : ID/EX hold and bubble controls (flush wins)
//   Rs1DataE..ValidE : registered ID/EX outputs
// -----------------------------------------------------------------------------
module decode_regfile_stage
    import decode_regfile_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    decode_regfile_stage_if.slave  wbBus,
    input  logic [AW-1:0]          Rs1D,
    input  logic [AW-1:0]          Rs2D,
    input  logic [AW-1:0]          RdInD,
    input  logic                   ValidD,
    input  logic                   StallE,
    input  logic                   FlushE,
    output logic [XLEN-1:0]        Rs1DataE,
    output logic [XLEN-1:0]        Rs2DataE,
    output logic [AW-1:0]          Rs1E,
    output logic [AW-1:0]          Rs2E,
    output logic [AW-1:0]          RdE,
    output logic                   ValidE
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    idex_t           idexNext;
    idex_t           idexQ;

    // Register writes ignore StallE/FlushE so a writeback is never lost.
    reg_file_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) uRegFile (
        .clk     (clk),
        .rst     (rst),
        .wrAddr  (wbBus.RdD),
        .wrData  (wbBus.ResultD),
        .wrEn    (wbBus.RegWriteEnD),
        .rdAddr1 (Rs1D),
        .rdAddr2 (Rs2D),
        .rdData1 (op1),
        .rdData2 (op2)
    );

    // NOTE: every field is assigned on every path through this block, so no
    // latch is inferred.
    always_comb begin
        idexNext.rs1Data = op1;
        idexNext.rs2Data = op2;
        idexNext.rs1     = Rs1D;
        idexNext.rs2     = Rs2D;
        idexNext.rd      = RdInD;
        idexNext.valid   = ValidD;
    end

    // Priority: reset, then flush (bubble), then stall (hold), then capture.
    // A held entry deliberately keeps stale operand data; the execute-stage
    // hazard unit forwards any newer value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idexQ <= '0;
        end else if (FlushE) begin
            idexQ <= '0;
        end else if (!StallE) begin
            idexQ <= idexNext;
        end
    end

    assign Rs1DataE = idexQ.rs1Data;
    assign Rs2DataE = idexQ.rs2Data;
    assign Rs1E     = idexQ.rs1;
    assign Rs2E     = idexQ.rs2;
    assign RdE      = idexQ.rd;
    assign ValidE   = idexQ.valid;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_regfile_stage
// Directed, table-driven bench for decode_regfile_stage. Each table row is one
// clock cycle: inputs are applied before the rising edge and the ID/EX outputs
// are compared 1 ns after it against hand-computed values.
// -----------------------------------------------------------------------------
module tb_decode_regfile_stage;
    import decode_regfile_stage_pkg::*;

    typedef struct {
        logic            rstN;
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] res;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rdIn;
        logic            validD;
        logic            stall;
        logic            flush;
        logic [XLEN-1:0] expD1;
        logic [XLEN-1:0] expD2;
        logic [AW-1:0]   expRs1;
        logic [AW-1:0]   expRs2;
        logic [AW-1:0]   expRd;
        logic            expValid;
    } vec_t;

    localparam int OW = 2 * XLEN + 3 * AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   Rs1D;
    logic [AW-1:0]   Rs2D;
    logic [AW-1:0]   RdInD;
    logic            ValidD;
    logic            StallE;
    logic            FlushE;
    logic [XLEN-1:0] Rs1DataE;
    logic [XLEN-1:0] Rs2DataE;
    logic [AW-1:0]   Rs1E;
    logic [AW-1:0]   Rs2E;
    logic [AW-1:0]   RdE;
    logic            ValidE;

    int numApplied = 0;
    int numMiscompares = 0;

    vec_t vecs[$];

    decode_regfile_stage_if wbBus ();

    decode_regfile_stage dut (
        .clk      (clk),
        .rst      (rst),
        .wbBus    (wbBus.slave),
        .Rs1D     (Rs1D),
        .Rs2D     (Rs2D),
        .RdInD    (RdInD),
        .ValidD   (ValidD),
        .StallE   (StallE),
        .FlushE   (FlushE),
        .Rs1DataE (Rs1DataE),
        .Rs2DataE (Rs2DataE),
        .Rs1E     (Rs1E),
        .Rs2E     (Rs2E),
        .RdE      (RdE),
        .ValidE   (ValidE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] actual,
                         input logic [OW-1:0] expected);
        numApplied++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("FAIL %s: got {d1,d2,rs1,rs2,rd,v}=%h required %h",
                     name, actual, expected);
        end
    endtask

    function automatic logic [OW-1:0] outs();
        return {Rs1DataE, Rs2DataE, Rs1E, Rs2E, RdE, ValidE};
    endfunction

    task automatic drive(input vec_t v);
        rst               = v.rstN;
        wbBus.RegWriteEnD = v.we;
        wbBus.RdD         = v.rd;
        wbBus.ResultD     = v.res;
        Rs1D              = v.rs1;
        Rs2D              = v.rs2;
        RdInD             = v.rdIn;
        ValidD            = v.validD;
        StallE            = v.stall;
        FlushE            = v.flush;
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(name, outs(),
              {v.expD1, v.expD2, v.expRs1, v.expRs2, v.expRd, v.expValid});
    endtask

    initial begin
        // rstN we rd res          rs1 rs2 rdIn vD st fl | d1 d2 rs1 rs2 rd v
        vecs.push_back('{0, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{0, 1, 4, 32'h1,        4,  0,  3, 1, 0, 0, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{1, 0, 0, 32'h0,        5,  31, 0, 0, 0, 0, 32'h0,        32'h0,        5,  31, 0, 0});
        vecs.push_back('{1, 1, 10, 32'hAABBCCDD, 10, 0,  1, 1, 0, 0, 32'hAABBCCDD, 32'h0,        10, 0,  1, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        10, 10, 2, 1, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 10, 10, 2, 1});
        vecs.push_back('{1, 1, 3, 32'h11111111, 0,  0,  0, 0, 0, 0, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{1, 1, 3, 32'h11223344, 3,  3,  3, 1, 0, 0, 32'h11223344, 32'h11223344, 3,  3,  3, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        3,  10, 0, 0, 0, 0, 32'h11223344, 32'hAABBCCDD, 3,  10, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h55667788, 0,  3,  4, 1, 0, 0, 32'h0,        32'h11223344, 0,  3,  4, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        0,  0,  0, 1, 0, 0, 32'h0,        32'h0,        0,  0,  0, 1});
        vecs.push_back('{1, 1, 5, 32'h00005555, 3,  5,  6, 1, 0, 0, 32'h11223344, 32'h00005555, 3,  5,  6, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        7,  10, 7, 1, 0, 0, 32'h0,        32'hAABBCCDD, 7,  10, 7, 1});
        vecs.push_back('{1, 1, 7, 32'hDEADBEEF, 3,  3,  9, 0, 1, 0, 32'h0,        32'hAABBCCDD, 7,  10, 7, 1});
        vecs.push_back('{1, 1, 7, 32'hDEADBEEF, 7,  7,  9, 0, 1, 0, 32'h0,        32'hAABBCCDD, 7,  10, 7, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        7,  7,  9, 0, 1, 0, 32'h0,        32'hAABBCCDD, 7,  10, 7, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        7,  7,  7, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 7,  7,  7, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        3,  10, 5, 1, 1, 1, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{1, 0, 0, 32'h0,        3,  10, 5, 1, 0, 1, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{1, 1, 4, 32'hCAFEF00D, 3,  0,  8, 1, 0, 0, 32'h11223344, 32'h0,        3,  0,  8, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        4,  0,  8, 1, 0, 0, 32'hCAFEF00D, 32'h0,        4,  0,  8, 1});
        vecs.push_back('{0, 1, 4, 32'h12345678, 4,  0,  8, 1, 0, 0, 32'h0,        32'h0,        0,  0,  0, 0});
        vecs.push_back('{1, 0, 0, 32'h0,        4,  7,  1, 1, 0, 0, 32'h0,        32'h0,        4,  7,  1, 1});
        vecs.push_back('{1, 0, 0, 32'h0,        3,  10, 1, 1, 0, 0, 32'h0,        32'h0,        3,  10, 1, 1});

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Several writes land while the ID/EX register is held; none may be
        // lost, and the held entry must not pick them up.
        step('{1, 0, 0,  32'h0,        1,  2,  3, 1, 0, 0, 32'h0, 32'h0, 1, 2, 3, 1}, "seqLoad");
        step('{1, 1, 12, 32'h0F0F0F0F, 12, 13, 4, 0, 1, 0, 32'h0, 32'h0, 1, 2, 3, 1}, "seqStallWr12");
        step('{1, 1, 13, 32'hF0F0F0F0, 12, 13, 4, 0, 1, 0, 32'h0, 32'h0, 1, 2, 3, 1}, "seqStallWr13");
        // Flush together with a write: bubble in E, write still committed.
        step('{1, 1, 14, 32'h14141414, 12, 13, 4, 1, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0}, "seqFlushWr14");
        step('{1, 0, 0,  32'h0,        12, 13, 5, 1, 0, 0,
               32'h0F0F0F0F, 32'hF0F0F0F0, 12, 13, 5, 1}, "seqReadBack");
        // Write to x0 bypassed to neither port while a real write-index is read.
        step('{1, 1, 0,  32'hFFFFFFFF, 0,  14, 6, 1, 0, 0,
               32'h0, 32'h14141414, 0, 14, 6, 1}, "seqX0Bypass");
        // A stalled entry must not be refreshed by a write to its source register.
        step('{1, 0, 0,  32'h0,        14, 14, 7, 1, 0, 0,
               32'h14141414, 32'h14141414, 14, 14, 7, 1}, "seqLoad14");
        step('{1, 1, 14, 32'h99999999, 14, 14, 7, 1, 1, 0,
               32'h14141414, 32'h14141414, 14, 14, 7, 1}, "seqStallHazard");
        step('{1, 0, 0,  32'h0,        14, 14, 7, 1, 0, 0,
               32'h99999999, 32'h99999999, 14, 14, 7, 1}, "seqAfterHazard");

        $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion required completion by 100000");
        $fatal(1);
    end

endmodule
